// File: rtl/stream_pkg.sv
// Shared types and the next-byte rule for the valid/ready byte stream source.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_DEC   = 2'd3
    } mode_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Byte that follows d in the given mode; all arithmetic wraps modulo 256.
    function automatic logic [7:0] next_data(input mode_t mode, input logic [7:0] d);
        logic [7:0] nxt;
        case (mode)
            MODE_INC:   nxt = d + 8'd1;
            MODE_CONST: nxt = d;
            MODE_LFSR:  nxt = (d >> 1) ^ (d[0] ? LFSR_TAPS : 8'h00);
            MODE_DEC:   nxt = d - 8'd1;
            default:    nxt = d;
        endcase
        return nxt;
    endfunction

    // The Galois LFSR locks up at zero, so a zero seed is promoted to 8'h01.
    function automatic logic [7:0] sanitize_seed(input mode_t mode, input logic [7:0] seed);
        logic [7:0] s;
        s = seed;
        if ((mode == MODE_LFSR) && (seed == 8'h00)) begin
            s = 8'h01;
        end
        return s;
    endfunction

endpackage

// File: rtl/stream_pattern_gen.sv
// Combinational pattern generator: next byte of the sequence and the
// sanitised first byte. Kept standalone so a sink-side checker can predict data.
module stream_pattern_gen
    import stream_pkg::*;
(
    input  mode_t      i_mode,
    input  logic [7:0] i_data,
    input  logic [7:0] i_seed,
    output logic [7:0] o_next,
    output logic [7:0] o_seed
);

    assign o_next = next_data(i_mode, i_data);
    assign o_seed = sanitize_seed(i_mode, i_seed);

endmodule

// File: rtl/stream_source.sv
// Transmit end of the 8-bit valid/ready byte stream: sends a programmed burst
// with optional idle gaps between transfers and reports completion.
module stream_source
    import stream_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       seed_i,
    input  logic [1:0]       mode_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [7:0]       data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] beat_cnt_o
);

    state_t           r_state, w_state_nxt;
    logic             r_valid, w_valid_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic [LEN_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    mode_t            r_mode, w_mode_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;

    mode_t            w_mode_sel;
    logic [7:0]       w_next;
    logic [7:0]       w_seed;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_xfer;

    // In IDLE the incoming mode decides seed sanitising; afterwards the captured mode rules.
    assign w_mode_sel = (r_state == IDLE) ? mode_t'(mode_i) : r_mode;
    assign w_xfer     = r_valid & ready_i;
    assign w_cnt_inc  = r_beat_cnt + LEN_W'(1);

    stream_pattern_gen u_pattern (
        .i_mode (w_mode_sel),
        .i_data (r_data),
        .i_seed (seed_i),
        .o_next (w_next),
        .o_seed (w_seed)
    );

    // Next-state and next-register values; every output is registered so
    // valid/data never follow ready combinationally.
    always_comb begin
        w_state_nxt    = r_state;
        w_valid_nxt    = r_valid;
        w_data_nxt     = r_data;
        w_beat_cnt_nxt = r_beat_cnt;
        w_len_nxt      = r_len;
        w_mode_nxt     = r_mode;
        w_gap_nxt      = r_gap;
        w_gap_cnt_nxt  = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_len_nxt      = len_i;
                    w_mode_nxt     = mode_t'(mode_i);
                    w_gap_nxt      = gap_i;
                    w_beat_cnt_nxt = '0;
                    if (len_i != '0) begin
                        w_data_nxt  = w_seed;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = SEND;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            SEND: begin
                if (w_xfer) begin
                    w_beat_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = DONE;
                    end else begin
                        w_data_nxt = w_next;
                        if (r_gap != '0) begin
                            w_valid_nxt   = 1'b0;
                            w_gap_cnt_nxt = r_gap;
                            w_state_nxt   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                // Re-asserting valid on the cycle the counter reads 1 yields exactly r_gap idle cycles.
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_gap_cnt_nxt = '0;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = SEND;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and burst-parameter registers; reset clears them so an aborted burst leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_data     <= 8'h00;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_mode     <= MODE_INC;
            r_gap      <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_len      <= w_len_nxt;
            r_mode     <= w_mode_nxt;
            r_gap      <= w_gap_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
        end
    end

    assign valid_o    = r_valid;
    assign data_o     = r_data;
    assign beat_cnt_o = r_beat_cnt;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);

endmodule

// File: tb/tb_stream_source.sv
// Directed bench for stream_source: bursts in each mode, stall, gaps, empty burst,
// ignored restart and mid-burst reset.
module tb_stream_source;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] len_i = 8'd0;
    logic [7:0] seed_i = 8'd0;
    logic [1:0] mode_i = 2'd0;
    logic [3:0] gap_i = 4'd0;
    logic       ready_i = 1'b1;
    logic       valid_o;
    logic [7:0] data_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] beat_cnt_o;

    int checks = 0;
    int errors = 0;

    stream_source #(.LEN_W(8), .GAP_W(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .seed_i     (seed_i),
        .mode_i     (mode_i),
        .gap_i      (gap_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .beat_cnt_o (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a burst request for one edge; returns #1 after the accepting edge.
    task automatic launch(input logic [7:0] seed, input logic [7:0] len,
                          input logic [1:0] mode, input logic [3:0] gap);
        seed_i  = seed;
        len_i   = len;
        mode_i  = mode;
        gap_i   = gap;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        seed_i  = 8'h5A;
        len_i   = 8'd9;
        mode_i  = 2'd1;
        gap_i   = 4'd7;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid_o, busy_o, done_o} !== 3'b000 || data_o !== 8'h00 || beat_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b b=%b d=%b data=%h cnt=%0d want all zero",
                     valid_o, busy_o, done_o, data_o, beat_cnt_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_inc_burst();
        logic [7:0] exp_data;
        ready_i = 1'b1;
        launch(8'h10, 8'd4, 2'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            exp_data = 8'h10 + 8'(i);
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_data || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL inc_beat%0d: got v=%b data=%h busy=%b want v=1 data=%h busy=1",
                         i, valid_o, data_o, busy_o, exp_data);
            end
            tick();
        end
        checks++;
        if (done_o !== 1'b1 || valid_o !== 1'b0 || beat_cnt_o !== 8'd4) begin
            errors++;
            $display("FAIL inc_done: got done=%b v=%b cnt=%0d want done=1 v=0 cnt=4",
                     done_o, valid_o, beat_cnt_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || beat_cnt_o !== 8'd4) begin
            errors++;
            $display("FAIL inc_idle: got done=%b busy=%b cnt=%0d want done=0 busy=0 cnt=4",
                     done_o, busy_o, beat_cnt_o);
        end
    endtask

    task automatic test_stall();
        ready_i = 1'b1;
        launch(8'h10, 8'd4, 2'd0, 4'd0);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h10 || beat_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL stall_first: got v=%b data=%h cnt=%0d want v=1 data=10 cnt=0",
                     valid_o, data_o, beat_cnt_o);
        end
        tick();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || data_o !== 8'h11 || beat_cnt_o !== 8'd1) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b data=%h cnt=%0d want v=1 data=11 cnt=1",
                         i, valid_o, data_o, beat_cnt_o);
            end
        end
        ready_i = 1'b1;
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h12) begin
            errors++;
            $display("FAIL stall_resume: got v=%b data=%h want v=1 data=12", valid_o, data_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h13) begin
            errors++;
            $display("FAIL stall_last: got v=%b data=%h want v=1 data=13", valid_o, data_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || beat_cnt_o !== 8'd4) begin
            errors++;
            $display("FAIL stall_done: got done=%b cnt=%0d want done=1 cnt=4", done_o, beat_cnt_o);
        end
        tick();
    endtask

    task automatic test_gap();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'hFE;
        exp_seq[1] = 8'hFF;
        exp_seq[2] = 8'h00;
        ready_i = 1'b1;
        launch(8'hFE, 8'd3, 2'd0, 4'd2);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_seq[b]) begin
                errors++;
                $display("FAIL gap_beat%0d: got v=%b data=%h want v=1 data=%h",
                         b, valid_o, data_o, exp_seq[b]);
            end
            tick();
            if (b < 2) begin
                for (int g = 0; g < 2; g++) begin
                    checks++;
                    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
                        errors++;
                        $display("FAIL gap_idle%0d_%0d: got v=%b busy=%b want v=0 busy=1",
                                 b, g, valid_o, busy_o);
                    end
                    tick();
                end
            end
        end
        checks++;
        if (done_o !== 1'b1 || beat_cnt_o !== 8'd3 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL gap_done: got done=%b cnt=%0d v=%b want done=1 cnt=3 v=0",
                     done_o, beat_cnt_o, valid_o);
        end
        tick();
    endtask

    task automatic test_lfsr();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h01;
        exp_seq[1] = 8'hB8;
        exp_seq[2] = 8'h5C;
        ready_i = 1'b1;
        launch(8'h00, 8'd3, 2'd2, 4'd0);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_seq[b]) begin
                errors++;
                $display("FAIL lfsr_beat%0d: got v=%b data=%h want v=1 data=%h",
                         b, valid_o, data_o, exp_seq[b]);
            end
            tick();
        end
        checks++;
        if (done_o !== 1'b1 || beat_cnt_o !== 8'd3) begin
            errors++;
            $display("FAIL lfsr_done: got done=%b cnt=%0d want done=1 cnt=3", done_o, beat_cnt_o);
        end
        tick();
    endtask

    task automatic test_zero_len_and_restart();
        ready_i = 1'b1;
        launch(8'h33, 8'd0, 2'd0, 4'd0);
        checks++;
        if (valid_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b1 || beat_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL zero_len: got v=%b done=%b busy=%b cnt=%0d want v=0 done=1 busy=1 cnt=0",
                     valid_o, done_o, busy_o, beat_cnt_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: got done=%b busy=%b v=%b want all 0",
                     done_o, busy_o, valid_o);
        end
        // Second start while busy must be ignored.
        ready_i = 1'b0;
        launch(8'h20, 8'd2, 2'd0, 4'd0);
        seed_i  = 8'h99;
        len_i   = 8'd7;
        mode_i  = 2'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h20 || beat_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL restart_ignored: got v=%b data=%h cnt=%0d want v=1 data=20 cnt=0",
                     valid_o, data_o, beat_cnt_o);
        end
        ready_i = 1'b1;
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h21) begin
            errors++;
            $display("FAIL restart_beat2: got v=%b data=%h want v=1 data=21", valid_o, data_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || beat_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL restart_done: got done=%b cnt=%0d want done=1 cnt=2", done_o, beat_cnt_o);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b1;
        launch(8'h30, 8'd5, 2'd0, 4'd0);
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h31) begin
            errors++;
            $display("FAIL abort_pre: got v=%b data=%h want v=1 data=31", valid_o, data_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || beat_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL abort_reset: got v=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                     valid_o, busy_o, done_o, beat_cnt_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got done=%b v=%b want done=0 v=0", done_o, valid_o);
        end
        launch(8'h40, 8'd2, 2'd3, 4'd0);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h40) begin
            errors++;
            $display("FAIL post_reset_b0: got v=%b data=%h want v=1 data=40", valid_o, data_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h3F) begin
            errors++;
            $display("FAIL post_reset_b1: got v=%b data=%h want v=1 data=3f", valid_o, data_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || beat_cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL post_reset_done: got done=%b cnt=%0d want done=1 cnt=2", done_o, beat_cnt_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_inc_burst();
        test_stall();
        test_gap();
        test_lfsr();
        test_zero_len_and_restart();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_source.md
Name: stream_source

Overview:
- Transmit end of the 8-bit valid/ready byte stream. Generates and sends a programmed burst of bytes to a downstream sink or FIFO write side.
- Software or a testbench loads a seed, a length, a data mode and an inter-beat gap, then pulses start_i.
- The block drives each byte with full valid/ready handshake and back-pressure, and reports completion.
- Used as the traffic generator for the fifo sub-project and as the stimulus end for sink verification.

Parameters:
- LEN_W, 8, width of burst length and beat counter (max burst 2^LEN_W-1 beats)
- GAP_W, 4, width of inter-beat idle-gap field

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  launch burst; sampled only in IDLE
- len_i  in  LEN_W  number of beats in the burst; captured on accepted start
- seed_i  in  8  first data byte; captured on accepted start
- mode_i  in  2  data mode: 0 increment, 1 constant, 2 LFSR, 3 decrement
- gap_i  in  GAP_W  idle cycles inserted after each transfer
- valid_o  out  1  data_o holds a valid byte
- ready_i  in  1  sink can accept this cycle
- data_o  out  8  stream byte
- busy_o  out  1  burst in progress (state != IDLE)
- done_o  out  1  one-cycle pulse when burst completes
- beat_cnt_o  out  LEN_W  transfers completed in the current or last burst

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE; valid_o=0, data_o=0, busy_o=0, done_o=0, beat_cnt_o=0; internal length, gap counter, mode and LFSR cleared. Reset asserted mid-burst aborts the burst: no done pulse, valid_o low after that edge.
- Transfer: occurs on an edge where valid_o=1 and ready_i=1.
  - valid_o and data_o are registered and never depend combinationally on ready_i.
  - While valid_o=1 and ready_i=0, data_o is held stable and valid_o stays high; no retraction.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE, start_i=1, len_i!=0 -> SEND. Captures len/mode/gap; data_o<=seed (seed 0 in LFSR mode becomes 8'h01); valid_o<=1; beat_cnt_o<=0; busy_o<=1. The first byte is valid on the cycle after start (latency 1).
  - IDLE, start_i=1, len_i==0 -> DONE. No beats sent; beat_cnt_o<=0.
  - SEND, no transfer: hold.
  - SEND, transfer, beat_cnt_o+1==len: valid_o<=0; beat_cnt_o increments; -> DONE.
  - SEND, transfer, more beats, gap==0: beat_cnt_o increments; data_o<=next(data_o); valid_o stays 1 (back-to-back, one beat per cycle at full throughput).
  - SEND, transfer, more beats, gap!=0: beat_cnt_o increments; valid_o<=0; gap counter<=gap; data_o<=next; -> GAP.
  - GAP: counter decrements each cycle. On the cycle it reads 1, valid_o<=1 and -> SEND, so exactly gap idle cycles occur between transfers.
  - DONE: done_o=1 for exactly one cycle; busy_o<=0; -> IDLE. beat_cnt_o retains its final value until the next accepted start.
- start_i outside IDLE is ignored. Changes on len_i/seed_i/mode_i/gap_i outside an accepted start have no effect.
- next() rules, all 8-bit modulo:
  - increment: +1, wraps 8'hFF->8'h00
  - constant: unchanged
  - decrement: -1, wraps 8'h00->8'hFF
  - LFSR: Galois right-shift, taps 8'hB8: next = (d>>1) ^ (d[0] ? 8'hB8 : 0); never reaches 0
- Beat counter compares against captured length. A burst of 2^LEN_W-1 beats completes without counter overflow.

Decomposition:
- Package stream_pkg:
  - typedef enum state_t {IDLE, SEND, GAP, DONE}
  - typedef enum mode_t {MODE_INC, MODE_CONST, MODE_LFSR, MODE_DEC}
  - localparam LFSR_TAPS = 8'hB8
  - function next_data(mode, d)
- Sub-module stream_pattern_gen: combinational next-byte function plus seed sanitising, so the sink-side checker can reuse it for expected-data prediction.

Test Plan:
- seed=8'h10, len=4, mode=INC, gap=0, ready_i=1 -> data 10,11,12,13 on 4 consecutive cycles starting 1 cycle after start; done_o pulses the cycle after the 4th transfer; beat_cnt_o=4.
- Same burst with ready_i low for 3 cycles while data=8'h11 -> valid_o stays 1 and data_o stays 8'h11 through the stall; sequence unchanged; total 4 transfers.
- seed=8'hFE, len=3, mode=INC, gap=2 -> data FE,FF,00; exactly 2 cycles of valid_o=0 between transfers; done after the 3rd.
- mode=LFSR, seed=0, len=3 -> data 01, B8, 5C.
- len=0 with start -> no valid_o; done_o pulses at start+1; beat_cnt_o=0. start_i re-pulsed while busy -> ignored, burst unaffected.
- rst_i asserted during the 2nd beat of a len=5 burst -> valid_o=0 and busy_o=0 after that edge, no done_o; a new start afterwards runs a clean burst.
